// File: rtl/operand_forward_unit.sv
// Execute-stage operand controller: shadows EX/MEM/WB destination info, drives the
// ALU input-1 source select and both forwarding selects, and raises the load-use stall.
module operand_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic [REG_ADDR_W-1:0] idRd,
  input  logic                  idRegWrite,
  input  logic                  idMemRead,
  input  logic [SEL_W-1:0]      idOp1Kind,
  input  logic                  idUsesRs2,
  input  logic                  flush,
  output logic                  stall,
  output logic                  exValid,
  output logic [SEL_W-1:0]      exInput1Select,
  output logic [SEL_W-1:0]      exForward1,
  output logic [SEL_W-1:0]      exForward2
);

  localparam logic [SEL_W-1:0] SEL_REG = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);

  logic                  ex_valid, ex_reg_write, ex_mem_read, ex_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [SEL_W-1:0]      ex_op1_kind;
  logic                  mem_valid, mem_reg_write, mem_mem_read;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_valid, wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;

  logic ex_writer, mem_writer, wb_writer;
  logic hazard, bubble;

  assign ex_writer  = ex_valid  && ex_reg_write  && (ex_rd  != '0);
  assign mem_writer = mem_valid && mem_reg_write && (mem_rd != '0);
  assign wb_writer  = wb_valid  && wb_reg_write  && (wb_rd  != '0);

  // A load in EX cannot supply its data until WB, so a dependent ID instruction must wait.
  assign hazard = idValid && ex_writer && ex_mem_read &&
                  (((idOp1Kind == SEL_REG) && (idRs1 == ex_rd)) ||
                   (idUsesRs2 && (idRs2 == ex_rd)));
  assign stall  = hazard && !flush;
  assign bubble = stall || flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_op1_kind   <= '0;
      ex_uses_rs2   <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
    end else begin
      wb_valid      <= mem_valid;
      wb_rd         <= mem_rd;
      wb_reg_write  <= mem_reg_write;
      mem_valid     <= ex_valid;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      if (bubble) begin
        ex_valid     <= 1'b0;
        ex_rs1       <= '0;
        ex_rs2       <= '0;
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_op1_kind  <= '0;
        ex_uses_rs2  <= 1'b0;
      end else begin
        ex_valid     <= idValid;
        ex_rs1       <= idRs1;
        ex_rs2       <= idRs2;
        ex_rd        <= idRd;
        ex_reg_write <= idRegWrite;
        ex_mem_read  <= idMemRead;
        ex_op1_kind  <= idOp1Kind;
        ex_uses_rs2  <= idUsesRs2;
      end
    end
  end

  // MEM is checked before WB so the younger result wins when both match.
  always_comb begin
    exForward1 = SEL_REG;
    if (ex_valid && (ex_op1_kind == SEL_REG)) begin
      if (mem_writer && (mem_rd == ex_rs1))      exForward1 = SEL_MEM;
      else if (wb_writer && (wb_rd == ex_rs1))   exForward1 = SEL_WB;
    end
  end

  always_comb begin
    exForward2 = SEL_REG;
    if (ex_valid && ex_uses_rs2) begin
      if (mem_writer && (mem_rd == ex_rs2))      exForward2 = SEL_MEM;
      else if (wb_writer && (wb_rd == ex_rs2))   exForward2 = SEL_WB;
    end
  end

  assign exValid        = ex_valid;
  assign exInput1Select = ex_valid ? ex_op1_kind : SEL_REG;

endmodule
